// File: rtl/fir_pkg.sv
// Shared definitions for the fir filter block and its sequencer.
// Control encodings and the default bus geometry live here so both sides agree.
package fir_pkg;

  localparam logic [1:0] FIR_CTRL_NOP = 2'b00;
  localparam logic [1:0] FIR_CTRL_RUN = 2'b01;
  localparam logic [1:0] FIR_CTRL_CLR = 2'b10;

  localparam int FIR_ADDR_STRIDE = 4;
  localparam int FIR_RD_LAT      = 2;

endpackage

// File: rtl/fir_seq.sv
// fir_seq: runs one fir job (clear, load, run, poll, read back) from a single start pulse.
// Samples arrive on a valid/ready stream; results leave on another.
//
// state  | meaning
// IDLE   | waiting for start
// CLR    | fir_ctrl = CLR for one cycle
// GAP    | fir_ctrl = NOP for one cycle
// LOAD   | accept N_SAMPLES words, write each to (k+1)*stride
// LOAD0  | rewrite address 0 with sample 0
// KICK   | fir_ctrl = RUN for one cycle
// SETTLE | one cycle before fir_bsy is trusted
// POLL   | wait for fir_bsy low, bounded by TIMEOUT
// RADDR  | present result address (r+1)*stride
// RWAIT  | wait RD_LAT cycles for fir_dout
// OUT    | offer captured result until m_ready
// FIN    | done pulse, then IDLE
module fir_seq
  import fir_pkg::*;
#(
  parameter int N_SAMPLES   = 36,
  parameter int DW          = 16,
  parameter int AW          = 16,
  parameter int ADDR_STRIDE = FIR_ADDR_STRIDE,
  parameter int RD_LAT      = FIR_RD_LAT,
  parameter int TIMEOUT     = 4096
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic          err,
  input  logic          s_valid,
  output logic          s_ready,
  input  logic [DW-1:0] s_data,
  output logic          m_valid,
  input  logic          m_ready,
  output logic [DW-1:0] m_data,
  output logic [1:0]    fir_ctrl,
  output logic [AW-1:0] fir_addr,
  output logic [DW-1:0] fir_din,
  input  logic [DW-1:0] fir_dout,
  input  logic          fir_bsy
);

  localparam int KW = (N_SAMPLES > 1) ? $clog2(N_SAMPLES) : 1;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int LW = $clog2(RD_LAT + 1);
  localparam longint MAX_ADDR = longint'(N_SAMPLES) * longint'(ADDR_STRIDE);

  generate
    if (MAX_ADDR > ((longint'(1) << AW) - 1)) begin : g_addr_chk
      $error("fir_seq: N_SAMPLES*ADDR_STRIDE does not fit in AW bits");
    end
    if (N_SAMPLES < 2 || RD_LAT < 1 || TIMEOUT < 1) begin : g_param_chk
      $error("fir_seq: need N_SAMPLES>=2, RD_LAT>=1, TIMEOUT>=1");
    end
  endgenerate

  localparam logic [3:0] ST_IDLE   = 4'd0;
  localparam logic [3:0] ST_CLR    = 4'd1;
  localparam logic [3:0] ST_GAP    = 4'd2;
  localparam logic [3:0] ST_LOAD   = 4'd3;
  localparam logic [3:0] ST_LOAD0  = 4'd4;
  localparam logic [3:0] ST_KICK   = 4'd5;
  localparam logic [3:0] ST_SETTLE = 4'd6;
  localparam logic [3:0] ST_POLL   = 4'd7;
  localparam logic [3:0] ST_RADDR  = 4'd8;
  localparam logic [3:0] ST_RWAIT  = 4'd9;
  localparam logic [3:0] ST_OUT    = 4'd10;
  localparam logic [3:0] ST_FIN    = 4'd11;

  logic [3:0]    state_q, state_d;
  logic [KW-1:0] k_q, k_d;
  logic [KW-1:0] r_q, r_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [LW-1:0] lat_q, lat_d;
  logic [DW-1:0] s0_q, s0_d;
  logic          err_q, err_d;
  logic          done_q, done_d;
  logic          busy_q, busy_d;
  logic          m_valid_q, m_valid_d;
  logic [DW-1:0] m_data_q, m_data_d;
  logic [1:0]    fir_ctrl_q, fir_ctrl_d;
  logic [AW-1:0] fir_addr_q, fir_addr_d;
  logic [DW-1:0] fir_din_q, fir_din_d;

  logic          s_hs;
  logic [AW-1:0] k_addr;
  logic [AW-1:0] r_addr;

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    r_d     = r_q;
    tmo_d   = tmo_q;
    lat_d   = lat_q;
    s0_d    = s0_q;
    err_d   = err_q;
    m_data_d = m_data_q;

    s_hs   = s_valid && (state_q == ST_LOAD);
    k_addr = (AW'(k_q) + AW'(1)) * AW'(ADDR_STRIDE);

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          err_d   = 1'b0;
          state_d = ST_CLR;
        end
      end
      ST_CLR:   state_d = ST_GAP;
      ST_GAP: begin
        k_d     = '0;
        state_d = ST_LOAD;
      end
      ST_LOAD: begin
        if (s_hs) begin
          if (k_q == '0) s0_d = s_data;
          if (k_q == KW'(N_SAMPLES - 1)) state_d = ST_LOAD0;
          else                            k_d     = k_q + KW'(1);
        end
      end
      ST_LOAD0: state_d = ST_KICK;
      ST_KICK:  state_d = ST_SETTLE;
      ST_SETTLE: begin
        tmo_d   = TW'(TIMEOUT - 1);
        state_d = ST_POLL;
      end
      ST_POLL: begin
        if (!fir_bsy) begin
          r_d     = '0;
          state_d = ST_RADDR;
        end else if (tmo_q == '0) begin
          err_d   = 1'b1;
          state_d = ST_FIN;
        end else begin
          tmo_d = tmo_q - TW'(1);
        end
      end
      ST_RADDR: begin
        lat_d   = LW'(RD_LAT - 1);
        state_d = ST_RWAIT;
      end
      ST_RWAIT: begin
        if (lat_q == '0) begin
          m_data_d = fir_dout;
          state_d  = ST_OUT;
        end else begin
          lat_d = lat_q - LW'(1);
        end
      end
      ST_OUT: begin
        if (m_ready) begin
          if (r_q == KW'(N_SAMPLES - 1)) begin
            state_d = ST_FIN;
          end else begin
            r_d     = r_q + KW'(1);
            state_d = ST_RADDR;
          end
        end
      end
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // Registered outputs are a function of the state being entered.
    r_addr     = (AW'(r_d) + AW'(1)) * AW'(ADDR_STRIDE);
    busy_d     = (state_d != ST_IDLE);
    done_d     = (state_d == ST_FIN);
    m_valid_d  = (state_d == ST_OUT);
    fir_ctrl_d = (state_d == ST_CLR)  ? FIR_CTRL_CLR :
                 (state_d == ST_KICK) ? FIR_CTRL_RUN : FIR_CTRL_NOP;
    fir_din_d  = (state_d == ST_LOAD0) ? s0_d : '0;
    if (state_d == ST_RADDR)
      fir_addr_d = r_addr;
    else if (state_d == ST_RWAIT || state_d == ST_OUT)
      fir_addr_d = fir_addr_q;
    else
      fir_addr_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      k_q        <= '0;
      r_q        <= '0;
      tmo_q      <= '0;
      lat_q      <= '0;
      s0_q       <= '0;
      err_q      <= 1'b0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
      m_valid_q  <= 1'b0;
      m_data_q   <= '0;
      fir_ctrl_q <= FIR_CTRL_NOP;
      fir_addr_q <= '0;
      fir_din_q  <= '0;
    end else begin
      state_q    <= state_d;
      k_q        <= k_d;
      r_q        <= r_d;
      tmo_q      <= tmo_d;
      lat_q      <= lat_d;
      s0_q       <= s0_d;
      err_q      <= err_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
      m_valid_q  <= m_valid_d;
      m_data_q   <= m_data_d;
      fir_ctrl_q <= fir_ctrl_d;
      fir_addr_q <= fir_addr_d;
      fir_din_q  <= fir_din_d;
    end
  end

  // In LOAD the write port follows the handshake combinationally; idle cycles park on address 0.
  assign s_ready  = (state_q == ST_LOAD);
  assign fir_addr = (state_q == ST_LOAD) ? (s_hs ? k_addr : '0) : fir_addr_q;
  assign fir_din  = (state_q == ST_LOAD) ? (s_hs ? s_data : s0_q) : fir_din_q;

  assign busy     = busy_q;
  assign done     = done_q;
  assign err      = err_q;
  assign m_valid  = m_valid_q;
  assign m_data   = m_data_q;
  assign fir_ctrl = fir_ctrl_q;

endmodule

// File: tb/tb_fir_seq.sv
// Bench for fir_seq: behavioural fir model plus write/result scoreboards.
module tb_fir_seq;

  localparam int N = 36;

  localparam int M_NORMAL   = 0;
  localparam int M_STALL    = 1;
  localparam int M_TMO      = 2;
  localparam int M_BSTART   = 3;
  localparam int M_RST_POLL = 4;
  localparam int M_RST_OUT  = 5;

  logic        clk;
  logic        rst;
  logic        start;
  logic        busy, done, err;
  logic        s_valid, s_ready;
  logic [15:0] s_data;
  logic        m_valid, m_ready;
  logic [15:0] m_data;
  logic [1:0]  fir_ctrl;
  logic [15:0] fir_addr, fir_din, fir_dout;
  logic        fir_bsy;

  fir_seq #(
    .N_SAMPLES(N), .DW(16), .AW(16), .ADDR_STRIDE(4), .RD_LAT(2), .TIMEOUT(64)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .err(err),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .fir_ctrl(fir_ctrl), .fir_addr(fir_addr), .fir_din(fir_din),
    .fir_dout(fir_dout), .fir_bsy(fir_bsy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // fir model: busy for 50 cycles after RUN, reads return addr/4 + 100 two cycles later
  logic [15:0] a1 = '0, a2 = '0;
  int          bsy_cnt = 0;
  bit          bsy_stuck = 1'b0;
  always @(posedge clk) begin
    a1 <= fir_addr;
    a2 <= a1;
    if (fir_ctrl == 2'b01)  bsy_cnt <= 50;
    else if (bsy_cnt > 0)   bsy_cnt <= bsy_cnt - 1;
  end
  assign fir_bsy  = bsy_stuck || (bsy_cnt != 0);
  assign fir_dout = (a2 >> 2) + 16'd100;

  int n_chk = 0, n_fail = 0;
  int cyc = 0, src_idx = 0, res_cnt = 0, done_cnt = 0;
  int last_res_cyc = 0, done_cyc = 0, settle_cyc = 0;
  bit stall = 1'b0, src_en = 1'b0, s_acc = 1'b0, m_hold = 1'b0, mv_seen = 1'b0;
  logic [15:0] m_last = '0;
  logic [31:0] exp_wr[$];
  logic [15:0] exp_res[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // One clock: drive inputs just after the rising edge, observe at the falling edge.
  task automatic tick();
    @(posedge clk);
    #1;
    start = 1'b0;
    rst   = 1'b0;
    if (s_acc) begin
      s_valid = 1'b0;
      s_acc   = 1'b0;
    end
    if (src_en && !s_valid && src_idx < N && (!stall || $urandom_range(3) == 0)) begin
      s_valid = 1'b1;
      s_data  = 16'(src_idx + 1);
      exp_wr.push_back({16'((src_idx + 1) * 4), 16'(src_idx + 1)});
    end
    m_ready = stall ? ($urandom_range(2) != 0) : 1'b1;

    @(negedge clk);
    cyc++;
    if (s_valid && s_ready) begin
      if (exp_wr.size() == 0) chk("wr_extra", src_idx, N);
      else begin
        logic [31:0] e;
        e = exp_wr.pop_front();
        chk("wr_addr", fir_addr, e[31:16]);
        chk("wr_data", fir_din, e[15:0]);
      end
      src_idx++;
      s_acc = 1'b1;
    end else if (s_ready && !s_valid) begin
      chk("idle_addr", fir_addr, 0);
    end

    if (m_hold) begin
      chk("m_vhold", m_valid, 1);
      chk("m_dstable", m_data, m_last);
    end
    m_hold = 1'b0;
    if (m_valid) begin
      mv_seen = 1'b1;
      if (m_ready) begin
        if (exp_res.size() == 0) chk("res_extra", res_cnt, N);
        else chk("result", m_data, exp_res.pop_front());
        if (!stall && res_cnt > 0) chk("res_gap", cyc - last_res_cyc, 4);
        res_cnt++;
        last_res_cyc = cyc;
      end else begin
        m_hold = 1'b1;
        m_last = m_data;
      end
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_err"}, err, 0);
    chk({tag, "_srdy"}, s_ready, 0);
    chk({tag, "_mvalid"}, m_valid, 0);
    chk({tag, "_mdata"}, m_data, 0);
    chk({tag, "_ctrl"}, fir_ctrl, 0);
    chk({tag, "_addr"}, fir_addr, 0);
    chk({tag, "_din"}, fir_din, 0);
  endtask

  task automatic do_reset(input string tag);
    rst     = 1'b1;
    s_valid = 1'b0;
    s_acc   = 1'b0;
    src_en  = 1'b0;
    m_hold  = 1'b0;
    tick();
    check_zero(tag);
    exp_wr.delete();
    exp_res.delete();
  endtask

  task automatic run_job(input int mode);
    stall     = (mode == M_STALL);
    bsy_stuck = (mode == M_TMO);
    src_idx   = 0;
    res_cnt   = 0;
    done_cnt  = 0;
    mv_seen   = 1'b0;
    if (mode != M_TMO)
      for (int i = 0; i < N; i++) exp_res.push_back(16'(i + 101));
    src_en = 1'b1;
    start  = 1'b1;
    tick();
    chk("clr_ctrl", fir_ctrl, 2'b10);
    chk("clr_busy", busy, 1);
    chk("clr_err", err, 0);
    tick();
    chk("gap_ctrl", fir_ctrl, 2'b00);
    chk("gap_srdy", s_ready, 0);
    tick();
    chk("load_srdy", s_ready, 1);
    for (int i = 0; i < 4000; i++) begin
      if (src_idx >= N) break;
      if (mode == M_BSTART && i == 3) start = 1'b1;
      tick();
    end
    chk("load_cnt", src_idx, N);
    tick();
    chk("ld0_addr", fir_addr, 0);
    chk("ld0_din", fir_din, 1);
    chk("ld0_srdy", s_ready, 0);
    tick();
    chk("kick_ctrl", fir_ctrl, 2'b01);
    tick();
    chk("settle_ctrl", fir_ctrl, 2'b00);
    settle_cyc = cyc;
    src_en = 1'b0;

    if (mode == M_RST_POLL) begin
      repeat (5) tick();
      chk("poll_busy", busy, 1);
      do_reset("rst_poll");
      return;
    end
    if (mode == M_RST_OUT) begin
      for (int i = 0; i < 500; i++) begin
        if (m_valid) break;
        tick();
      end
      chk("out_seen", m_valid, 1);
      do_reset("rst_out");
      return;
    end

    for (int i = 0; i < 5000; i++) begin
      if (done_cnt != 0) break;
      tick();
    end
    chk("done_seen", done_cnt, 1);
    tick();
    chk("idle_busy", busy, 0);
    chk("idle_done", done, 0);
    tick();
    tick();
    chk("done_once", done_cnt, 1);
    if (mode == M_TMO) begin
      chk("tmo_err", err, 1);
      chk("tmo_no_mvalid", mv_seen, 0);
      chk("tmo_lat", done_cyc - settle_cyc, 65);
    end else begin
      chk("job_err", err, 0);
      chk("res_cnt", res_cnt, N);
      chk("res_left", exp_res.size(), 0);
      chk("done_lat", done_cyc - last_res_cyc, 1);
    end
    chk("wr_left", exp_wr.size(), 0);
    bsy_stuck = 1'b0;
  endtask

  initial begin
    rst     = 1'b1;
    start   = 1'b0;
    s_valid = 1'b0;
    s_data  = '0;
    m_ready = 1'b0;
    rst     = 1'b1;
    tick();
    check_zero("reset");

    run_job(M_NORMAL);
    run_job(M_STALL);
    run_job(M_TMO);
    run_job(M_NORMAL);
    run_job(M_RST_POLL);
    run_job(M_NORMAL);
    run_job(M_RST_OUT);
    run_job(M_STALL);
    run_job(M_BSTART);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/fir_seq.md
# fir_seq

Sequencer that owns the `fir` block's control bus and runs one complete filter job without host polling. On `start` it clears the filter, streams `N_SAMPLES` input words from a valid/ready source into the filter's sample memory, and kicks a run. It then waits for `fir_bsy` to drop, reads every result back, and emits the results on a valid/ready output stream. It sits between the sample DMA/stream fabric and `fir`, replacing testbench-style register poking.

## Interface
- `N_SAMPLES`, 36: words per job (≥2).
- `DW`, 16: sample/result width.
- `AW`, 16: `fir` address width.
- `ADDR_STRIDE`, 4: byte stride between sample/result words.
- `RD_LAT`, 2: cycles from `fir_addr` change to valid `fir_dout`.
- `TIMEOUT`, 4096: maximum `POLL` cycles before abort.
- `clk`, in, 1: clock, rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `start`, in, 1: job request; sampled only in `IDLE`.
- `busy`, out, 1: high in every state except `IDLE`.
- `done`, out, 1: one-cycle pulse at job end (normal or abort).
- `err`, out, 1: set on timeout; cleared on next accepted `start` or reset.
- `s_valid`/`s_ready`/`s_data`, in/out/in, 1/1/DW: input sample stream.
- `m_valid`/`m_ready`/`m_data`, out/in/out, 1/1/DW: result stream.
- `fir_ctrl`, out, 2: `00` NOP, `01` RUN, `10` CLR.
- `fir_addr`, out, AW: `fir` word address.
- `fir_din`, out, DW: `fir` write data.
- `fir_dout`, in, DW: `fir` read data.
- `fir_bsy`, in, 1: `fir` busy.

## Operation
- **Reset values:** all outputs 0, state `IDLE`, counters 0, `s0` (sample-0 register) 0.
- **FSM:** IDLE → CLR → GAP → LOAD → LOAD0 → KICK → SETTLE → POLL → RADDR → RWAIT → OUT → (RADDR | FIN) → IDLE.
- **IDLE:** on `start`, clear `err`, go to `CLR`.
- **CLR:** `fir_ctrl`=10 for exactly one cycle.
- **GAP:** `fir_ctrl`=00 for one cycle.
- **LOAD:**
  - `s_ready`=1. On each handshake k (0..N_SAMPLES-1): `fir_addr`=(k+1)·ADDR_STRIDE, `fir_din`=`s_data`, same cycle. k=0 also stores `s0`.
  - Cycles without a handshake drive `fir_addr`=0, `fir_din`=`s0`, so no stray address is written.
  - After handshake N_SAMPLES-1, go to `LOAD0`.
- **LOAD0:** one cycle with `fir_addr`=0, `fir_din`=`s0`; `s_ready`=0.
- **KICK:** `fir_ctrl`=01 for one cycle.
- **SETTLE:** one cycle with `fir_ctrl`=00; `fir_bsy` is ignored here.
- **POLL:**
  - `fir_bsy`=0 → `RADDR` with result index r=0.
  - Cycle counter reaching TIMEOUT → set `err`, go to `FIN`, emit no results.
- **RADDR:** drive `fir_addr`=(r+1)·ADDR_STRIDE and hold it through `RWAIT`.
- **RWAIT:** wait RD_LAT cycles, then capture `fir_dout` into `m_data`.
- **OUT:**
  - `m_valid`=1 with `m_data` stable until `m_ready`.
  - On handshake: r=N_SAMPLES-1 → `FIN`, else r+1 → `RADDR`.
- **FIN:** `done`=1 for one cycle, `fir_addr`=0, then `IDLE`.
- **Width rule:** addresses are computed in AW bits; (N_SAMPLES)·ADDR_STRIDE must fit in AW (elaboration check).
- **`start` outside IDLE:** ignored; no queueing.
- **`rst` mid-job:** immediate return to reset values. The filter is left as is; the next job's `CLR` recovers it.

## Timing
- `start` high at cycle t:
  - `fir_ctrl`=10 at t+1, 00 at t+2.
  - `s_ready`=1 from t+3.
- Load with back-to-back samples: N_SAMPLES cycles + 1 (`LOAD0`).
- KICK occurs one cycle after `LOAD0`. The first `fir_bsy` sample is taken two cycles after KICK.
- Per result, with `m_ready` held high: 1 (`RADDR`) + RD_LAT (`RWAIT`) + 1 (`OUT`) cycles.
  - At RD_LAT=2: 4·N_SAMPLES cycles.
- `done` pulses the cycle after the last output handshake, or the cycle after the timeout is hit.
- Outputs are registered. Exceptions, which are combinational from the state: `s_ready`, `fir_addr`, `fir_din` in `LOAD`.

## Structure
- **`fir_pkg`** (shared with `fir`): ctrl encodings FIR_CTRL_NOP/RUN/CLR, default ADDR_STRIDE, RD_LAT.
- **Local to `fir_seq`:** state enum.
- **Sub-modules:** none required; a single module holding the FSM, k/r counters and timeout counter.

## Test plan
- **Nominal job:** N=36, samples 1..36 back-to-back, `fir` model returns addr/4 + 100 after bsy for 50 cycles → 36 results 101..136 in order, then one `done`, `err`=0.
- **Load order:** check the `fir` bus trace → CLR one cycle, GAP, writes at 4,8,…,144 with data 1..36, then addr 0/data 1, then RUN one cycle.
- **Stalls:** `s_valid` 25% duty and `m_ready` randomly low → the same write/result sequences, no duplicated or dropped words, `m_data` stable while stalled.
- **Timeout:** `fir_bsy` stuck at 1, TIMEOUT=64 → `err`=1, `done` pulse, `m_valid` never high. A new `start` clears `err`.
- **Reset mid-run:** assert `rst` during `POLL` and during `OUT` → next cycle all outputs 0, `busy`=0. A following job completes correctly.
- **Start while busy:** pulse `start` during `LOAD` → ignored, exactly one `done`.
